// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the common data bus (CDB) of the out-of-order core among its
// execution units (0 = int, 1 = mult, 2 = div, 3 = ld/st).
//
// Each unit hands over one completed result through a valid/ready handshake.
// The result is parked in that unit's holding register. One holder per cycle
// is granted in round-robin order, and the granted entry is broadcast on a
// registered CDB.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_flush         synchronous squash: drops every held entry
//   i_req_valid     per-requester valid
//   i_req_data      per-requester cdb_bfm result
//   o_req_ready     per-requester ready (from state, flush and reset only)
//   o_cdb           registered CDB broadcast
//   o_grant         registered one-hot owner of o_cdb
//   o_issue_done    registered one-cycle pulse to the owner's issue queue
// ---------------------------------------------------------------------------
package cdb_pkg;

    typedef struct packed {
        logic [5:0]  cdb_tag;
        logic [31:0] cdb_result;
        logic        cdb_valid;
        logic        cdb_branch;
        logic        cdb_branch_taken;
        logic        issue_done;
    } cdb_bfm;

endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_flush,
    input  logic [N_REQ-1:0]                     i_req_valid,
    input  logic [N_REQ-1:0][$bits(cdb_bfm)-1:0] i_req_data,
    output logic [N_REQ-1:0]                     o_req_ready,
    output logic [$bits(cdb_bfm)-1:0]            o_cdb,
    output logic [N_REQ-1:0]                     o_grant,
    output logic [N_REQ-1:0]                     o_issue_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    cdb_bfm [N_REQ-1:0] req_s;
    cdb_bfm [N_REQ-1:0] hold_d;
    logic   [N_REQ-1:0] hold_v;
    logic   [N_REQ-1:0] is_req;
    logic   [N_REQ-1:0] accept;
    logic   [N_REQ-1:0] gnt;
    logic   [PTR_W-1:0] last_ptr;
    logic   [PTR_W-1:0] gnt_idx;
    logic   [PTR_W-1:0] cand;
    logic               gnt_any;

    assign req_s = i_req_data;

    // A holder can take new data when it is empty, or when it is being
    // broadcast this cycle. This lets a lone requester sustain one result
    // per cycle.
    assign o_req_ready = (rst || i_flush) ? '0 : (~hold_v | gnt);
    assign accept      = i_req_valid & o_req_ready;

    // Entries with neither a register write nor a branch outcome still
    // complete the handshake, but they never occupy a holder.
    always_comb begin
        is_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            is_req[i] = req_s[i].cdb_valid | req_s[i].cdb_branch;
        end
    end

    // Round-robin search over the holders. It starts one past the last
    // winner, so the worst-case wait for a held entry is N_REQ cycles.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(last_ptr) + 1 + k) % N_REQ);
            if (!gnt_any && hold_v[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Holding registers. A new load takes priority over the clear caused
    // by a grant, so a holder that is granted and reloaded in the same
    // cycle stays full with the new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v <= '0;
            hold_d <= '0;
        end else if (i_flush) begin
            hold_v <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i] && is_req[i]) begin
                    hold_v[i] <= 1'b1;
                    hold_d[i] <= req_s[i];
                end else if (gnt[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    // Registered broadcast. The outputs load zero when there is no grant,
    // so a result never appears on the bus twice. The pointer moves only
    // when a grant occurs, and it survives a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cdb        <= '0;
            o_grant      <= '0;
            o_issue_done <= '0;
            last_ptr     <= PTR_W'(N_REQ - 1);
        end else if (i_flush || !gnt_any) begin
            o_cdb        <= '0;
            o_grant      <= '0;
            o_issue_done <= '0;
        end else begin
            o_cdb        <= hold_d[gnt_idx];
            o_grant      <= gnt;
            o_issue_done <= gnt;
            last_ptr     <= gnt_idx;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the execution units of the out-of-order RISC-V core: integer issue, multiplier, divider and load/store. Each unit hands over one completed `cdb_bfm` result through a valid/ready handshake. The arbiter parks the result in a per-unit holding register and grants one holder per cycle in round-robin order. The granted entry drives the registered CDB that feeds the register status table, reservation stations and branch logic.

## Interface
- `N_REQ`, default 4: number of requesters. Index 0 = int, 1 = mult, 2 = div, 3 = ld/st.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `i_flush`, input, 1: synchronous squash (branch mispredict).
- `i_req_valid`, input, N_REQ: requester i offers a result.
- `i_req_data`, input, N_REQ x `$bits(cdb_bfm)`: result from requester i (`cdb_tag`, `cdb_result`, `cdb_valid`, `cdb_branch`, `cdb_branch_taken`, `issue_done`).
- `o_req_ready`, output, N_REQ: holding register i can accept this cycle.
- `o_cdb`, output, `$bits(cdb_bfm)`: registered CDB broadcast.
- `o_grant`, output, N_REQ: registered one-hot marking the owner of the current `o_cdb`.
- `o_issue_done`, output, N_REQ: registered one-cycle pulse to requester i's issue queue when its entry is broadcast.

## Operation
- **Request condition.** An entry counts as a request only if `cdb_valid | cdb_branch`. If both are 0, the handshake still completes, but nothing is stored and nothing is broadcast.
- **Holding register.** Each requester has one holding register, `hold_v[i]` / `hold_d[i]`.
  - `o_req_ready[i] = !rst & !i_flush & (!hold_v[i] | gnt[i])`.
  - This allows full throughput from a single requester.
- **Arbitration.** Combinational, over `hold_v`.
  - Search starts at `(last_ptr+1) mod N_REQ` and wraps; the first set `hold_v` wins as `gnt`.
  - `last_ptr` updates to the winner's index only when a grant occurs.
  - `last_ptr` resets to N_REQ-1, so requester 0 has priority first.
- **Edge update when a grant occurs:**
  - `o_cdb <= hold_d[w]`, `o_grant <= onehot(w)`, `o_issue_done[w] <= 1`.
  - `hold_v[w]` clears unless it is reloaded by a simultaneous handshake on requester w.
- **No grant:** `o_cdb`, `o_grant` and `o_issue_done` load all-zero. A broadcast is never repeated.
- **Simultaneous grant and new handshake on the same requester:** the new data is loaded and `hold_v` stays 1. The old data goes to the CDB.
- **Flush** (`i_flush`=1 at an edge):
  - All `hold_v` clear.
  - `o_cdb` / `o_grant` / `o_issue_done` load zero.
  - `last_ptr` is unchanged.
  - Ready is 0 during flush, so no handshake happens that cycle.
- **Reset** (`rst`=1, any time including mid-operation): `hold_v`=0, `hold_d`=0, `o_cdb`=0, `o_grant`=0, `o_issue_done`=0, `last_ptr`=N_REQ-1. `o_req_ready`=0 while `rst` is high and all 1 in the first cycle after release.
- **Branch entries** (`cdb_branch`=1, `cdb_valid`=0) are arbitrated exactly like writes and occupy one CDB slot.

## Timing
- Handshake at edge E (valid & ready) → `hold_v` set in cycle E+1.
  - If granted in E+1, the result is on `o_cdb` in cycle E+2. Minimum latency is 2 cycles.
- Throughput is one CDB broadcast per cycle total. A lone requester can sustain one per cycle.
- Worst-case wait for a held entry is N_REQ cycles, so the arbiter is starvation-free.
- `o_issue_done[i]` is asserted in the same cycle as the matching `o_cdb` and lasts exactly one cycle.
- `o_req_ready` is combinational from state, `i_flush` and `rst` only. It never depends on `i_req_valid`.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 holds full → all outputs 0 immediately; after release ready=4'b1111, and no stale broadcast ever appears.
- **Single int request:** tag=5, result=32'h0000_0007, `cdb_valid`=1, handshake at cycle 1 → `o_cdb`.tag=5 and result=7 in cycle 3, `o_grant`=4'b0001 and `o_issue_done`=4'b0001 for one cycle.
- **All four requesters, same cycle:** tags 1,2,3,4 presented together → broadcasts in order 1,2,3,4 on consecutive cycles. With a repeat burst, order continues from the pointer (int next).
- **Back-to-back from int:** 8 consecutive results from int only → 8 consecutive `o_cdb` cycles, ready held high throughout.
- **Branch entry:** `cdb_branch`=1, `cdb_branch_taken`=1, `cdb_valid`=0 from int, alongside a mult write tag=9 → both broadcast on separate cycles in round-robin order.
- **Flush:** `i_flush` with 2 holds full and a new request presented → next cycle `o_cdb`=0, `hold_v`=0, the presented request is not accepted, and no `o_issue_done` pulse for the dropped entries.
